// File: rtl/complex_nr_acc.sv
// complex_nr_acc: accumulates ACC_LEN complex products into a signed complex
// sum and hands the sum downstream over a valid/ready handshake.
// Optional build macro: COMPLEX_ACC_SAT_EN -- when defined, each addition
// saturates per part instead of wrapping modulo 2^ACC_WIDTH.
module complex_nr_acc #(
  parameter  int DATA_WIDTH = 8,
  parameter  int ACC_LEN    = 4,
  parameter  int ACC_WIDTH  = 20,
  localparam int PW         = 2*DATA_WIDTH+1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 sw_rst,
  input  logic                 res_val,
  output logic                 res_ready,
  input  logic [PW-1:0]        res_re,
  input  logic [PW-1:0]        res_im,
  output logic                 acc_val,
  input  logic                 acc_ready,
  output logic [ACC_WIDTH-1:0] acc_re,
  output logic [ACC_WIDTH-1:0] acc_im,
  output logic                 acc_ovf
);

  localparam int CNT_W = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_LEN-1);

  typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

  state_t                          state_reg;
  logic [CNT_W-1:0]                cnt_reg;
  logic [1:0][ACC_WIDTH-1:0]       acc_reg;
  logic                            ovf_reg;
  logic                            res_ready_reg;
  logic                            acc_val_reg;

  // Part 0 is the real lane, part 1 the imaginary lane.
  logic [1:0][PW-1:0]              prod;
  logic [1:0][ACC_WIDTH:0]         sum_wide;
  logic [1:0][ACC_WIDTH-1:0]       sum_next;
  logic [1:0]                      part_ovf;

  assign prod[0] = res_re;
  assign prod[1] = res_im;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_part
      // One guard bit above the accumulator exposes signed overflow.
      assign sum_wide[gi] = {acc_reg[gi][ACC_WIDTH-1], acc_reg[gi]}
                          + {{(ACC_WIDTH+1-PW){prod[gi][PW-1]}}, prod[gi]};
      assign part_ovf[gi] = sum_wide[gi][ACC_WIDTH] ^ sum_wide[gi][ACC_WIDTH-1];
`ifdef COMPLEX_ACC_SAT_EN
      // Clamp toward the true sign of the wide result.
      assign sum_next[gi] = !part_ovf[gi] ? sum_wide[gi][ACC_WIDTH-1:0] :
                            sum_wide[gi][ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                                    : {1'b0, {(ACC_WIDTH-1){1'b1}}};
`else
      assign sum_next[gi] = sum_wide[gi][ACC_WIDTH-1:0];
`endif
    end
  endgenerate

  // Control FSM with registered handshake outputs and the accumulator datapath.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      acc_reg       <= '0;
      ovf_reg       <= 1'b0;
      res_ready_reg <= 1'b0;
      acc_val_reg   <= 1'b0;
    end else if (sw_rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      acc_reg       <= '0;
      ovf_reg       <= 1'b0;
      res_ready_reg <= 1'b0;
      acc_val_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          state_reg     <= ACC;
          res_ready_reg <= 1'b1;
          acc_val_reg   <= 1'b0;
        end
        ACC: begin
          if (res_val && res_ready_reg) begin
            acc_reg <= sum_next;
            if (|part_ovf) ovf_reg <= 1'b1;
            if (cnt_reg == CNT_LAST) begin
              cnt_reg       <= '0;
              state_reg     <= OUT;
              res_ready_reg <= 1'b0;
              acc_val_reg   <= 1'b1;
            end else begin
              cnt_reg <= cnt_reg + CNT_W'(1);
            end
          end
        end
        OUT: begin
          if (acc_ready) begin
            acc_reg       <= '0;
            ovf_reg       <= 1'b0;
            state_reg     <= ACC;
            res_ready_reg <= 1'b1;
            acc_val_reg   <= 1'b0;
          end
        end
        default: begin
          state_reg     <= IDLE;
          cnt_reg       <= '0;
          res_ready_reg <= 1'b0;
          acc_val_reg   <= 1'b0;
        end
      endcase
    end
  end

  assign res_ready = res_ready_reg;
  assign acc_val   = acc_val_reg;
  assign acc_re    = acc_reg[0];
  assign acc_im    = acc_reg[1];
  assign acc_ovf   = ovf_reg;

endmodule
